// File: rtl/evm_ballot_core_pkg.sv
// Shared types for the EVM ballot controller.
//   evm_state_e : voter-sequence FSM states
//   MODE_*      : encodings of the mode input
package evm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StVerified,
        StBallot,
        StLockout
    } evm_state_e;

    localparam logic MODE_VOTE   = 1'b0;
    localparam logic MODE_RESULT = 1'b1;

endpackage

// File: rtl/evm_ballot_core_if.sv
// Front-panel bundle of the EVM ballot controller.
//   master : panel side (drives buttons/mode/serial, reads LEDs and display)
//   slave  : controller side
interface evm_ballot_core_if #(
    parameter int unsigned NUM_CAND = 4,
    parameter int unsigned VOTER_W  = 5,
    parameter int unsigned CNT_W    = 8
);
    logic                mode_i;
    logic                checker_i;
    logic [VOTER_W-1:0]  serial_i;
    logic                auth_i;
    logic [NUM_CAND-1:0] cand_btn_i;
    logic                red_led_o;
    logic                green_led_o;
    logic                vote_ok_o;
    logic                dup_reject_o;
    logic [CNT_W-1:0]    disp_count_o;
    logic [NUM_CAND-1:0] sat_o;

    modport master (
        output mode_i, checker_i, serial_i, auth_i, cand_btn_i,
        input  red_led_o, green_led_o, vote_ok_o, dup_reject_o, disp_count_o, sat_o
    );

    modport slave (
        input  mode_i, checker_i, serial_i, auth_i, cand_btn_i,
        output red_led_o, green_led_o, vote_ok_o, dup_reject_o, disp_count_o, sat_o
    );
endinterface

// File: rtl/evm_ballot_core_btn_debounce.sv
// Button debouncer: one registered single-cycle pulse after the button has
// been sampled high on DEBOUNCE consecutive edges; it re-arms only once the
// button has been sampled low.
//   clock, reset : design clock, async active-low reset
//   btn_i        : raw button (assumed already synchronous to clock)
//   pulse_o      : debounced press pulse
module btn_debounce #(
    parameter int unsigned DEBOUNCE = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);
    localparam int unsigned CntW = $clog2(DEBOUNCE + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pulse_q, pulse_d;

    always_comb begin
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (btn_i) begin
            pulse_d = (cnt_q == CntW'(DEBOUNCE - 1));
            // Parking at DEBOUNCE blocks a second pulse while still held.
            cnt_d   = (cnt_q == CntW'(DEBOUNCE)) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;
endmodule

// File: rtl/evm_ballot_core.sv
// EVM ballot controller: debounces check/auth/candidate buttons, runs the
// verify -> authorise -> cast -> lockout sequence, keeps a used-voter bitmap
// and saturating per-candidate tallies, and drives the display value.
//   clock, reset : design clock, async active-low reset
//   bus (slave)  : mode/checker/serial/auth/cand_btn in;
//                  red/green LEDs, vote_ok, dup_reject, disp_count, sat out
module evm_ballot_core
    import evm_pkg::*;
#(
    parameter int unsigned NUM_CAND    = 4,
    parameter int unsigned NUM_VOTERS  = 32,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEBOUNCE    = 50000,
    parameter int unsigned LOCK_CYCLES = 10
) (
    input logic               clock,
    input logic               reset,
    evm_ballot_core_if.slave  bus
);
    localparam int unsigned VOTER_W = $clog2(NUM_VOTERS);
    localparam int unsigned SEL_W   = $clog2(NUM_CAND);
    localparam int unsigned LOCK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic                chk_p, auth_p;
    logic [NUM_CAND-1:0] cand_p;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_chk (
        .clock(clock), .reset(reset), .btn_i(bus.checker_i), .pulse_o(chk_p)
    );
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_auth (
        .clock(clock), .reset(reset), .btn_i(bus.auth_i), .pulse_o(auth_p)
    );
    for (genvar g = 0; g < NUM_CAND; g++) begin : g_cand_deb
        btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_cand (
            .clock(clock), .reset(reset), .btn_i(bus.cand_btn_i[g]), .pulse_o(cand_p[g])
        );
    end

    evm_state_e          state_q, state_d;
    logic [VOTER_W-1:0]  voter_q, voter_d;
    logic [NUM_VOTERS-1:0] used_q, used_d;
    logic [CNT_W-1:0]    tally_q [NUM_CAND];
    logic [CNT_W-1:0]    tally_d [NUM_CAND];
    logic [NUM_CAND-1:0] sat_q, sat_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic                vote_ok_q, vote_ok_d, dup_q, dup_d;

    logic [SEL_W-1:0]    cand_idx;
    logic                id_ok;

    // Lowest pressed index; also the index of the sole pulse when one-hot.
    always_comb begin
        cand_idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (cand_p[i]) cand_idx = SEL_W'(i);
        end
    end

    assign id_ok = (32'(bus.serial_i) < NUM_VOTERS);

    always_comb begin
        state_d   = state_q;
        voter_d   = voter_q;
        used_d    = used_q;
        tally_d   = tally_q;
        sat_d     = sat_q;
        sel_d     = sel_q;
        lock_d    = lock_q;
        vote_ok_d = 1'b0;
        dup_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.mode_i == MODE_RESULT) begin
                    if (|cand_p) sel_d = cand_idx;
                end else if (chk_p) begin
                    if (id_ok && !used_q[bus.serial_i]) begin
                        state_d = StVerified;
                        voter_d = bus.serial_i;
                    end else begin
                        dup_d = 1'b1;
                    end
                end
            end
            StVerified: begin
                if (bus.mode_i == MODE_RESULT) state_d = StIdle;
                else if (auth_p)               state_d = StBallot;
            end
            StBallot: begin
                if (bus.mode_i == MODE_RESULT) begin
                    state_d = StIdle;
                end else if ($onehot(cand_p)) begin
                    if (tally_q[cand_idx] == CntMax) sat_d[cand_idx] = 1'b1;
                    else tally_d[cand_idx] = tally_q[cand_idx] + 1'b1;
                    used_d[voter_q] = 1'b1;
                    vote_ok_d       = 1'b1;
                    lock_d          = '0;
                    state_d         = StLockout;
                end
            end
            StLockout: begin
                if (lock_q == LOCK_W'(LOCK_CYCLES - 1)) state_d = StIdle;
                else                                    lock_d  = lock_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            voter_q   <= '0;
            used_q    <= '0;
            tally_q   <= '{default: '0};
            sat_q     <= '0;
            sel_q     <= '0;
            lock_q    <= '0;
            vote_ok_q <= 1'b0;
            dup_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            voter_q   <= voter_d;
            used_q    <= used_d;
            tally_q   <= tally_d;
            sat_q     <= sat_d;
            sel_q     <= sel_d;
            lock_q    <= lock_d;
            vote_ok_q <= vote_ok_d;
            dup_q     <= dup_d;
        end
    end

    logic             red, green;
    logic [CNT_W-1:0] disp;

    always_comb begin
        red   = 1'b1;
        green = 1'b0;
        disp  = '0;
        case (state_q)
            StVerified: red = 1'b0;
            StBallot: begin
                red   = 1'b0;
                green = 1'b1;
            end
            StLockout: disp = '1;
            default: begin
                if (bus.mode_i == MODE_RESULT) disp = tally_q[sel_q];
            end
        endcase
    end

    assign bus.red_led_o    = red;
    assign bus.green_led_o  = green;
    assign bus.disp_count_o = disp;
    assign bus.vote_ok_o    = vote_ok_q;
    assign bus.dup_reject_o = dup_q;
    assign bus.sat_o        = sat_q;
endmodule

// File: doc/evm_ballot_core.md
# evm_ballot_core

Parametrised next-generation ballot controller for the EVM. It debounces NUM_CAND candidate buttons plus the check and auth buttons, and enforces the voter sequence verify → authorise → cast → lockout. A NUM_VOTERS-entry used-voter bitmap blocks repeat votes, and per-candidate tallies saturate instead of wrapping. It sits between the front-panel inputs and the existing bin-to-BCD / 7-segment display path, which consumes `disp_count`.

## Interface
- NUM_CAND, 4: number of candidates (≥2).
- NUM_VOTERS, 32: voter ID space; VOTER_W = $clog2(NUM_VOTERS), derived.
- CNT_W, 8: tally width per candidate.
- DEBOUNCE, 50000: consecutive high cycles a button must be held before it is accepted.
- LOCK_CYCLES, 10: post-vote lockout length in cycles.

Ports:
- clock  input  1  single design clock; all state on rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- mode  input  1  0 = voting, 1 = result.
- checker  input  1  raw voter-check button.
- serial  input  VOTER_W  voter ID, sampled on the debounced check pulse.
- auth  input  1  raw official-authorise button.
- cand_btn  input  NUM_CAND  raw candidate buttons.
- red_led  output  1  high = no voter cleared to vote.
- green_led  output  1  high = ballot open.
- vote_ok  output  1  one-cycle pulse when a vote is tallied.
- dup_reject  output  1  one-cycle pulse on a used or out-of-range voter ID.
- disp_count  output  CNT_W  display value.
- sat  output  NUM_CAND  per-candidate saturation flags.

## Operation
- Debouncers: one per raw button. Each produces a single one-cycle pulse once the button has been high for DEBOUNCE consecutive cycles. The button must return low before it can pulse again.
- FSM states: IDLE, VERIFIED, BALLOT, LOCKOUT. Reset state is IDLE.
- IDLE: red=1, green=0.
  - Check pulse with serial < NUM_VOTERS and used[serial]=0 → VERIFIED; serial is latched.
  - Check pulse with a used or out-of-range ID → dup_reject, stay in IDLE.
- VERIFIED: red=0, green=0.
  - Auth pulse → BALLOT.
  - Further check pulses are ignored.
- BALLOT: red=0, green=1.
  - Exactly one candidate pulse (one-hot) → tally[i] += 1 (or sets sat[i] if already at 2^CNT_W−1, holding the max value), used[latched]=1, vote_ok, → LOCKOUT.
  - Zero or multiple simultaneous candidate pulses → no effect, stay in BALLOT.
- LOCKOUT: red=1, green=0, disp_count = all ones. After LOCK_CYCLES cycles → IDLE.
- Abort on mode=1 while in VERIFIED or BALLOT: → IDLE. No tally change and no bitmap change; the voter may retry.
- Result mode (mode=1, FSM in IDLE):
  - Check and auth pulses are ignored.
  - A candidate pulse sets sel := i, with the lowest index winning on ties.
  - disp_count = tally[sel].
- Voting-mode display: disp_count = 0 except during LOCKOUT.
- Tallies and the bitmap persist across mode changes. Only reset clears them.

## Timing
- Button to pulse: button high at edge k, held through edge k+DEBOUNCE−1 → pulse asserted for the cycle after edge k+DEBOUNCE−1.
- All FSM transitions, tally updates, LED changes and vote_ok / dup_reject pulses are registered, one cycle after the input pulse.
- LOCKOUT lasts exactly LOCK_CYCLES cycles.
- sel updates one cycle after its candidate pulse. disp_count follows combinationally from registered sel and tally.
- Reset assertion, mid-operation: outputs go immediately to red=1, green=0, vote_ok=0, dup_reject=0, disp_count=0, sat=0. Tallies, bitmap, sel and debouncer counters are zeroed.
- Reset deassertion must be synchronised externally to clock.

## Structure
- Shared package `evm_pkg`: FSM state enum, mode encodings (MODE_VOTE, MODE_RESULT).
- One sub-module, `btn_debounce`, parametrised by DEBOUNCE (counter width = $clog2(DEBOUNCE+1)), instantiated NUM_CAND+2 times.
- Tallies are an array of NUM_CAND × CNT_W registers. The used bitmap is NUM_VOTERS flops.

## Test plan
- Normal vote, DEBOUNCE=4, LOCK_CYCLES=3: check serial=5, auth, cand_btn=0010 → tally[1]=1, one vote_ok, green high only in BALLOT, disp_count=0xFF for 3 cycles, then IDLE.
- Repeat voter: after the vote above, check serial=5 → dup_reject pulse, red stays 1, no tally change. serial=NUM_VOTERS → dup_reject.
- Simultaneous buttons in BALLOT: cand_btn=0110 → no tally change, stays in BALLOT. Then 0100 → tally[2]=1.
- Saturation, CNT_W=2: 4 voters choose candidate 0 → tally[0]=3, sat[0]=1 after the fourth vote. vote_ok still pulses and the voter is marked used.
- Abort and reset: mode→1 in BALLOT → IDLE, and serial is reusable. Asserting reset in LOCKOUT clears all tallies and the bitmap; outputs are at reset values in the same cycle.
- Result mode: mode=1, press cand_btn[2] → disp_count=tally[2] one cycle later. Check and auth pulses are ignored.
